// File: rtl/h14tx_pkg.sv
// rtl/h14tx_pkg.sv - HDMI TX packet types, packet kinds and ACR packet builder
package h14tx_pkg;

  // sub[i][7:0] is SB0 of subpacket i; header[7:0] is HB0
  typedef struct packed {
    logic [3:0][55:0] sub;
    logic [23:0]      header;
  } packet_t;

  typedef enum logic [2:0] {
    KIND_NULL      = 3'd0,
    KIND_ACR       = 3'd1,
    KIND_AUDIO     = 3'd2,
    KIND_INFOFRAME = 3'd3
  } pkt_kind_e;

  localparam logic [23:0] ACR_HEADER = 24'h000001;

  function automatic packet_t pack_acr(input logic [19:0] cts, input logic [19:0] n);
    packet_t     p;
    logic [55:0] sb;
    sb = {n[7:0], n[15:8], {4'h0, n[19:16]},
          cts[7:0], cts[15:8], {4'h0, cts[19:16]}, 8'h00};
    p.header = ACR_HEADER;
    for (int i = 0; i < 4; i++) begin
      p.sub[i] = sb;
    end
    return p;
  endfunction

endpackage

// File: rtl/h14tx_packet_picker.sv
// rtl/h14tx_packet_picker.sv - per-slot HDMI packet selection (ACR > audio > InfoFrame > null)
// Optional statistics counters enabled by H14TX_PICKER_STATS_EN.
module h14tx_packet_picker
  import h14tx_pkg::*;
#(
  parameter int IF_COUNT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         frame_start,
  input  logic                         acr_tick,
  input  logic [19:0]                  acr_cts,
  input  logic [19:0]                  acr_n,
  input  logic                         aud_valid,
  input  packet_t                      aud_pkt,
  output logic                         aud_ready,
  input  logic [IF_COUNT-1:0]          if_en,
  input  packet_t [IF_COUNT-1:0]       if_pkt,
  output packet_t                      packet,
  output pkt_kind_e                    kind
`ifdef H14TX_PICKER_STATS_EN
  ,
  input  logic                         stats_clr,
  output logic [7:0]                   acr_overrun_cnt,
  output logic [7:0]                   if_miss_cnt
`endif
);

  logic                   acr_pending;
  logic [19:0]            acr_cts_q;
  logic [19:0]            acr_n_q;
  logic [IF_COUNT-1:0]    if_pending;
  packet_t [IF_COUNT-1:0] if_shadow;

  packet_t                next_pkt;
  pkt_kind_e              next_kind;
  logic                   acr_sel;
  logic                   aud_sel;
  logic                   if_hit;
  logic                   if_take;
  logic [IF_COUNT-1:0]    if_clr;
  packet_t                if_sel_pkt;

  always_comb begin
    next_pkt   = '0;
    next_kind  = KIND_NULL;
    acr_sel    = 1'b0;
    aud_sel    = 1'b0;
    if_hit     = 1'b0;
    if_take    = 1'b0;
    if_clr     = '0;
    if_sel_pkt = '0;
    // descending scan so the lowest pending index is the one that sticks
    for (int i = IF_COUNT - 1; i >= 0; i--) begin
      if (if_pending[i]) begin
        if_hit     = 1'b1;
        if_clr     = '0;
        if_clr[i]  = 1'b1;
        if_sel_pkt = if_shadow[i];
      end
    end
    if (acr_pending) begin
      acr_sel   = 1'b1;
      next_pkt  = pack_acr(acr_cts_q, acr_n_q);
      next_kind = KIND_ACR;
    end else if (aud_valid) begin
      aud_sel   = 1'b1;
      next_pkt  = aud_pkt;
      next_kind = KIND_AUDIO;
    end else if (if_hit) begin
      if_take   = 1'b1;
      next_pkt  = if_sel_pkt;
      next_kind = KIND_INFOFRAME;
    end
  end

  assign aud_ready = load && !rst && aud_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      packet      <= '0;
      kind        <= KIND_NULL;
      acr_pending <= 1'b0;
      acr_cts_q   <= '0;
      acr_n_q     <= '0;
      if_pending  <= '0;
      if_shadow   <= '0;
    end else begin
      if (load) begin
        packet <= next_pkt;
        kind   <= next_kind;
      end
      // a fresh tick re-arms even when this load consumes the old ACR values
      if (acr_tick) begin
        acr_pending <= 1'b1;
        acr_cts_q   <= acr_cts;
        acr_n_q     <= acr_n;
      end else if (load && acr_sel) begin
        acr_pending <= 1'b0;
      end
      if (frame_start) begin
        if_shadow  <= if_pkt;
        if_pending <= if_en;
      end else if (load && if_take) begin
        if_pending <= if_pending & ~if_clr;
      end
    end
  end

`ifdef H14TX_PICKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      acr_overrun_cnt <= 8'd0;
      if_miss_cnt     <= 8'd0;
    end else begin
      if (acr_tick && acr_pending && acr_overrun_cnt != 8'hFF) begin
        acr_overrun_cnt <= acr_overrun_cnt + 8'd1;
      end
      if (frame_start && (|if_pending) && if_miss_cnt != 8'hFF) begin
        if_miss_cnt <= if_miss_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_h14tx_packet_picker.sv
// tb/tb_h14tx_packet_picker.sv - directed scoreboard bench for h14tx_packet_picker
// Stats checks compiled in when H14TX_PICKER_STATS_EN is defined.
module tb_h14tx_packet_picker;
  import h14tx_pkg::*;

  localparam int IF_COUNT = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   load;
  logic                   frame_start;
  logic                   acr_tick;
  logic [19:0]            acr_cts;
  logic [19:0]            acr_n;
  logic                   aud_valid;
  packet_t                aud_pkt;
  logic                   aud_ready;
  logic [IF_COUNT-1:0]    if_en;
  packet_t [IF_COUNT-1:0] if_pkt;
  packet_t                packet;
  pkt_kind_e              kind;
`ifdef H14TX_PICKER_STATS_EN
  logic                   stats_clr;
  logic [7:0]             acr_overrun_cnt;
  logic [7:0]             if_miss_cnt;
`endif

  typedef struct {
    packet_t   pkt;
    pkt_kind_e kind;
    string     tag;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  h14tx_packet_picker #(.IF_COUNT(IF_COUNT)) dut (
    .clk(clk), .rst(rst), .load(load), .frame_start(frame_start),
    .acr_tick(acr_tick), .acr_cts(acr_cts), .acr_n(acr_n),
    .aud_valid(aud_valid), .aud_pkt(aud_pkt), .aud_ready(aud_ready),
    .if_en(if_en), .if_pkt(if_pkt), .packet(packet), .kind(kind)
`ifdef H14TX_PICKER_STATS_EN
    , .stats_clr(stats_clr), .acr_overrun_cnt(acr_overrun_cnt), .if_miss_cnt(if_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic packet_t acr_model(input logic [19:0] c, input logic [19:0] n);
    logic [7:0] sb [7];
    packet_t    p;
    sb[0] = 8'h00;
    sb[1] = {4'h0, c[19:16]};
    sb[2] = c[15:8];
    sb[3] = c[7:0];
    sb[4] = {4'h0, n[19:16]};
    sb[5] = n[15:8];
    sb[6] = n[7:0];
    p.header = {8'h00, 8'h00, 8'h01};
    for (int s = 0; s < 4; s++)
      for (int b = 0; b < 7; b++)
        p.sub[s][b*8 +: 8] = sb[b];
    return p;
  endfunction

  function automatic packet_t mkp(input int unsigned s);
    packet_t p;
    p.header = 24'(s * 7 + 3);
    for (int i = 0; i < 4; i++) p.sub[i] = {24'(s), 32'(s * 13 + i)};
    return p;
  endfunction

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pkt(input string tag, input packet_t obs, input packet_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // load for one cycle; any acr_tick/frame_start/stats_clr set by the caller rides along
  task automatic load_step(input packet_t ep, input pkt_kind_e ek, input logic er, input string tag);
    exp_t e;
    e.pkt = ep; e.kind = ek; e.tag = tag;
    sb_q.push_back(e);
    load = 1'b1;
    #1;
    chk_val({tag, "_aud_ready"}, 64'(aud_ready), 64'(er));
    tick();
    load = 1'b0; acr_tick = 1'b0; frame_start = 1'b0;
`ifdef H14TX_PICKER_STATS_EN
    stats_clr = 1'b0;
`endif
    e = sb_q.pop_front();
    chk_pkt({e.tag, "_packet"}, packet, e.pkt);
    chk_val({e.tag, "_kind"}, 64'(kind), 64'(e.kind));
  endtask

  task automatic pulse_acr(input logic [19:0] c, input logic [19:0] n);
    acr_tick = 1'b1; acr_cts = c; acr_n = n;
    tick();
    acr_tick = 1'b0;
  endtask

  packet_t p_aud, s0, s1, s2, t0, t1, t2;

  initial begin
    rst = 1'b1; load = 1'b0; frame_start = 1'b0; acr_tick = 1'b0;
    acr_cts = '0; acr_n = '0; aud_valid = 1'b0; aud_pkt = '0;
    if_en = '0; if_pkt = '0;
`ifdef H14TX_PICKER_STATS_EN
    stats_clr = 1'b0;
`endif
    p_aud = mkp(32'h55); s0 = mkp(32'h100); s1 = mkp(32'h200); s2 = mkp(32'h300);
    t0 = mkp(32'h400); t1 = mkp(32'h500); t2 = mkp(32'h600);
    @(negedge clk);
    tick();
    chk_pkt("reset_packet", packet, '0);
    chk_val("reset_kind", 64'(kind), 64'(KIND_NULL));
    chk_val("reset_aud_ready", 64'(aud_ready), 64'd0);
    rst = 1'b0;
    tick();

    load_step('0, KIND_NULL, 1'b0, "idle_null");

    // ACR packing and pending clear
    pulse_acr(20'h12345, 20'h01800);
    load_step(acr_model(20'h12345, 20'h01800), KIND_ACR, 1'b0, "acr_basic");
    chk_val("acr_sub2_literal", 64'(packet.sub[2]), 64'h00180045230100);
    repeat (3) tick();
    chk_pkt("hold_no_load", packet, acr_model(20'h12345, 20'h01800));
    load_step('0, KIND_NULL, 1'b0, "acr_cleared");

    // ACR beats audio, then audio is consumed
    pulse_acr(20'hABCDE, 20'h06000);
    aud_valid = 1'b1; aud_pkt = p_aud;
    #1;
    chk_val("aud_ready_no_load", 64'(aud_ready), 64'd0);
    load_step(acr_model(20'hABCDE, 20'h06000), KIND_ACR, 1'b0, "acr_over_audio");
    load_step(p_aud, KIND_AUDIO, 1'b1, "audio");
    #1;
    chk_val("aud_ready_after_load", 64'(aud_ready), 64'd0);
    aud_valid = 1'b0;

    // ACR tick coincident with the load that sends ACR
    pulse_acr(20'h11111, 20'h22222);
    acr_tick = 1'b1; acr_cts = 20'h33333; acr_n = 20'h44444;
    load_step(acr_model(20'h11111, 20'h22222), KIND_ACR, 1'b0, "acr_coinc_old");
    load_step(acr_model(20'h33333, 20'h44444), KIND_ACR, 1'b0, "acr_coinc_new");

`ifdef H14TX_PICKER_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    pulse_acr(20'h00001, 20'h00002);
    pulse_acr(20'h00003, 20'h00004);
    chk_val("acr_overrun_cnt", 64'(acr_overrun_cnt), 64'd1);
    acr_tick = 1'b1; stats_clr = 1'b1;
    tick();
    acr_tick = 1'b0; stats_clr = 1'b0;
    chk_val("acr_overrun_clr_wins", 64'(acr_overrun_cnt), 64'd0);
    load_step(acr_model(20'h00003, 20'h00004), KIND_ACR, 1'b0, "acr_after_overrun");
`endif

    // InfoFrame shadowing and priority
    if_pkt[0] = s0; if_pkt[1] = s1; if_pkt[2] = s2; if_en = 3'b101;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if_pkt[0] = t0; if_pkt[2] = t2;
    load_step(s0, KIND_INFOFRAME, 1'b0, "if_avi");
    load_step(s2, KIND_INFOFRAME, 1'b0, "if_spd");
    load_step('0, KIND_NULL, 1'b0, "if_null1");
    load_step('0, KIND_NULL, 1'b0, "if_null2");

`ifdef H14TX_PICKER_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
`endif
    // frame_start coincident with a load selecting AVI
    if_pkt[0] = s0; if_pkt[1] = s1; if_pkt[2] = s2;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if_pkt[0] = t0; if_pkt[1] = t1; if_pkt[2] = t2;
    frame_start = 1'b1;
    load_step(s0, KIND_INFOFRAME, 1'b0, "if_coinc_old");
`ifdef H14TX_PICKER_STATS_EN
    chk_val("if_miss_cnt", 64'(if_miss_cnt), 64'd1);
`endif
    load_step(t0, KIND_INFOFRAME, 1'b0, "if_rearm_avi");
    load_step(t2, KIND_INFOFRAME, 1'b0, "if_rearm_spd");
    load_step('0, KIND_NULL, 1'b0, "if_rearm_null");

    // reset mid-slot discards pending work
    pulse_acr(20'h0ACE1, 20'h01234);
    load_step(acr_model(20'h0ACE1, 20'h01234), KIND_ACR, 1'b0, "acr_before_rst");
    pulse_acr(20'h0BEEF, 20'h05678);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_pkt("rst_packet", packet, '0);
    chk_val("rst_kind", 64'(kind), 64'(KIND_NULL));
    load_step('0, KIND_NULL, 1'b0, "post_rst_null");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
